// File: rtl/jt12_timer_ctrl_pkg.sv
// Shared register map and helper types for the JT12 timer control front end.
//   REG_*      : part-I register addresses decoded by jt12_timer_ctrl
//   TCTRL_*    : bit positions inside the 0x27 timer-control register
//   bus_wr_t   : one captured CPU write, held for a single cycle before it is applied
package jt12_timer_ctrl_pkg;

    localparam logic [7:0] REG_TA_HI = 8'h24;
    localparam logic [7:0] REG_TA_LO = 8'h25;
    localparam logic [7:0] REG_TB    = 8'h26;
    localparam logic [7:0] REG_TCTRL = 8'h27;

    localparam int unsigned TCTRL_LOAD_A  = 0;
    localparam int unsigned TCTRL_LOAD_B  = 1;
    localparam int unsigned TCTRL_EN_A    = 2;
    localparam int unsigned TCTRL_EN_B    = 3;
    localparam int unsigned TCTRL_CLR_A   = 4;
    localparam int unsigned TCTRL_CLR_B   = 5;
    localparam int unsigned TCTRL_CSM_LSB = 6;

    typedef struct packed {
        logic       is_data;  // addr[0]
        logic       part;     // addr[1]
        logic [7:0] din;
    } bus_wr_t;

endpackage

// File: rtl/jt12_busy_cnt.sv
// Write-busy timer. Loads BUSY_CYCLES when start is high and counts down to zero;
// a start while already counting simply reloads.
//   clk, rst : clock, asynchronous active-high reset
//   start    : 1-clk request to (re)load the counter
//   busy     : high while the counter is non-zero
module jt12_busy_cnt #(
    parameter int unsigned BUSY_CYCLES = 32,
    parameter int unsigned BUSY_W      = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy
);

    localparam logic [BUSY_W-1:0] LoadVal = BUSY_W'(BUSY_CYCLES);

    logic [BUSY_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = LoadVal;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - BUSY_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy = (cnt_q != '0);

endmodule

// File: rtl/jt12_timer_ctrl.sv
// CPU-facing register front end for the JT12 timer pair. Decodes part-I writes to
// 0x24..0x27 and produces the jt12_timers control set: presets, 1-clk load / clr_run /
// clr_flag pulses, IRQ enables and CSM mode. Returns {busy,5'b0,flag_B,flag_A} on dout.
// set_run_A/B of jt12_timers are tied low by the integrating level; timers start only
// through load_A/load_B.
//   clk, rst            : clock, asynchronous active-high reset
//   cs_n, wr_n          : active-low chip select / write strobe
//   addr                : [0] 0=address 1=data, [1] 0=part I 1=part II
//   din / dout          : CPU write data / registered status byte
//   flag_A, flag_B      : timer flags from jt12_timers
//   value_A, value_B    : timer presets
//   load_*, clr_run_*, clr_flag_* : 1-clk control pulses
//   enable_irq_*, csm_mode        : levels from register 0x27
//   busy                : high for BUSY_CYCLES clocks after each data write
module jt12_timer_ctrl
    import jt12_timer_ctrl_pkg::*;
#(
    parameter int unsigned BUSY_CYCLES = 32,
    parameter int unsigned BUSY_W      = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs_n,
    input  logic       wr_n,
    input  logic [1:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic       flag_A,
    input  logic       flag_B,
    output logic [9:0] value_A,
    output logic [7:0] value_B,
    output logic       load_A,
    output logic       load_B,
    output logic       clr_run_A,
    output logic       clr_run_B,
    output logic       clr_flag_A,
    output logic       clr_flag_B,
    output logic       enable_irq_A,
    output logic       enable_irq_B,
    output logic [1:0] csm_mode,
    output logic       busy
);

    logic       strobe_idle_q;  // strobe was inactive last cycle
    logic       wr_pend_q;
    bus_wr_t    wr_q;
    logic [7:0] sel_reg_q;
    logic       sel_part_q;
    logic       ld_a_q, ld_b_q;

    logic wr_evt, data_wr, timer_wr;

    // Edge-detect the strobe so a held cs_n/wr_n produces exactly one event.
    assign wr_evt   = ~cs_n & ~wr_n & strobe_idle_q;
    assign data_wr  = wr_pend_q & wr_q.is_data;
    assign timer_wr = data_wr & ~sel_part_q & ~wr_q.part;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            strobe_idle_q <= 1'b1;
            wr_pend_q     <= 1'b0;
            wr_q          <= '0;
            sel_reg_q     <= '0;
            sel_part_q    <= 1'b0;
            ld_a_q        <= 1'b0;
            ld_b_q        <= 1'b0;
            dout          <= '0;
            value_A       <= '0;
            value_B       <= '0;
            load_A        <= 1'b0;
            load_B        <= 1'b0;
            clr_run_A     <= 1'b0;
            clr_run_B     <= 1'b0;
            clr_flag_A    <= 1'b0;
            clr_flag_B    <= 1'b0;
            enable_irq_A  <= 1'b0;
            enable_irq_B  <= 1'b0;
            csm_mode      <= '0;
        end else begin
            strobe_idle_q <= cs_n | wr_n;
            wr_pend_q     <= wr_evt;
            if (wr_evt) begin
                wr_q <= {addr[0], addr[1], din};
            end

            load_A     <= 1'b0;
            load_B     <= 1'b0;
            clr_run_A  <= 1'b0;
            clr_run_B  <= 1'b0;
            clr_flag_A <= 1'b0;
            clr_flag_B <= 1'b0;

            dout <= {busy, 5'b0, flag_B, flag_A};

            if (wr_pend_q && !wr_q.is_data) begin
                sel_reg_q  <= wr_q.din;
                sel_part_q <= wr_q.part;
            end

            if (timer_wr) begin
                case (sel_reg_q)
                    REG_TA_HI: value_A[9:2] <= wr_q.din;
                    REG_TA_LO: value_A[1:0] <= wr_q.din[1:0];
                    REG_TB:    value_B      <= wr_q.din;
                    REG_TCTRL: begin
                        // Load only on a 0->1 of the stored bit so a running timer is
                        // not restarted; a 0 stops the timer on every write.
                        load_A       <= wr_q.din[TCTRL_LOAD_A] & ~ld_a_q;
                        load_B       <= wr_q.din[TCTRL_LOAD_B] & ~ld_b_q;
                        clr_run_A    <= ~wr_q.din[TCTRL_LOAD_A];
                        clr_run_B    <= ~wr_q.din[TCTRL_LOAD_B];
                        ld_a_q       <= wr_q.din[TCTRL_LOAD_A];
                        ld_b_q       <= wr_q.din[TCTRL_LOAD_B];
                        enable_irq_A <= wr_q.din[TCTRL_EN_A];
                        enable_irq_B <= wr_q.din[TCTRL_EN_B];
                        clr_flag_A   <= wr_q.din[TCTRL_CLR_A];
                        clr_flag_B   <= wr_q.din[TCTRL_CLR_B];
                        csm_mode     <= wr_q.din[TCTRL_CSM_LSB +: 2];
                    end
                    default: ;
                endcase
            end
        end
    end

    jt12_busy_cnt #(
        .BUSY_CYCLES (BUSY_CYCLES),
        .BUSY_W      (BUSY_W)
    ) u_busy (
        .clk   (clk),
        .rst   (rst),
        .start (data_wr),
        .busy  (busy)
    );

endmodule

// File: tb/tb_jt12_timer_ctrl.sv
module tb_jt12_timer_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cs_n = 1'b1;
    logic       wr_n = 1'b1;
    logic [1:0] addr = 2'b00;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic       flag_A = 1'b0;
    logic       flag_B = 1'b0;
    logic [9:0] value_A;
    logic [7:0] value_B;
    logic       load_A, load_B, clr_run_A, clr_run_B, clr_flag_A, clr_flag_B;
    logic       enable_irq_A, enable_irq_B, busy;
    logic [1:0] csm_mode;

    int n_vec = 0;
    int n_err = 0;

    // Pulse vector order: {clr_flag_B, clr_flag_A, clr_run_B, clr_run_A, load_B, load_A}
    logic [5:0] sb[$];

    always #5 clk = ~clk;

    jt12_timer_ctrl #(
        .BUSY_CYCLES (32),
        .BUSY_W      (6)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cs_n         (cs_n),
        .wr_n         (wr_n),
        .addr         (addr),
        .din          (din),
        .dout         (dout),
        .flag_A       (flag_A),
        .flag_B       (flag_B),
        .value_A      (value_A),
        .value_B      (value_B),
        .load_A       (load_A),
        .load_B       (load_B),
        .clr_run_A    (clr_run_A),
        .clr_run_B    (clr_run_B),
        .clr_flag_A   (clr_flag_A),
        .clr_flag_B   (clr_flag_B),
        .enable_irq_A (enable_irq_A),
        .enable_irq_B (enable_irq_B),
        .csm_mode     (csm_mode),
        .busy         (busy)
    );

    wire [5:0] pulses = {clr_flag_B, clr_flag_A, clr_run_B, clr_run_A, load_B, load_A};
    // {value_A, value_B, en_B, en_A, csm, busy}
    wire [22:0] levels = {value_A, value_B, enable_irq_B, enable_irq_A, csm_mode, busy};

    // Every non-zero pulse cycle must match the oldest expected pulse set.
    always @(negedge clk) begin
        if (!rst && pulses != 6'b0) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_pulse: got %b want none", pulses);
            end else begin
                logic [5:0] exp_p;
                exp_p = sb.pop_front();
                if (pulses !== exp_p) begin
                    n_err++;
                    $display("FAIL pulse_set: got %b want %b", pulses, exp_p);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // One bus write; returns just after the negedge following the apply edge.
    task automatic bus_write(input logic [1:0] a, input logic [7:0] d, input logic [5:0] exp_p);
        cs_n = 1'b0; wr_n = 1'b0; addr = a; din = d;
        if (exp_p != 6'b0) sb.push_back(exp_p);
        @(posedge clk); #1;
        cs_n = 1'b1; wr_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); #1;
        check("pulse_latency", 64'(sb.size()), 64'd0);
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (!busy) done = 1'b1;
        end
        check("busy_idle_timeout", 64'(done), 64'd1);
    endtask

    // Drive strobes at cycles s0/s1 and measure the busy window and dout[7] lag.
    task automatic busy_run(input int s1, input int exp_last, input string name);
        int  first_hi = -1;
        int  last_hi  = -1;
        int  dmis     = 0;
        logic prev_b  = 1'b0;
        addr = 2'b11; din = 8'h00;  // part-II data: ignored except for busy
        for (int k = 0; k < 60; k++) begin
            cs_n = !(k == 0 || k == s1);
            wr_n = cs_n;
            @(posedge clk);
            @(negedge clk);
            if (busy) begin
                if (first_hi < 0) first_hi = k;
                last_hi = k;
            end
            if (dout[7] !== prev_b) dmis++;
            prev_b = busy;
        end
        cs_n = 1'b1; wr_n = 1'b1;
        check({name, "_first"}, 64'(first_hi), 64'd1);
        check({name, "_last"}, 64'(last_hi), 64'(exp_last));
        check({name, "_dout7"}, 64'(dmis), 64'd0);
    endtask

    typedef struct {
        logic [1:0]  addr;
        logic [7:0]  din;
        logic [5:0]  pulse;
        logic [22:0] lvl;   // {va, vb, enB, enA, csm, busy}
    } vec_t;

    vec_t tbl[20];

    initial begin
        tbl[0]  = '{2'b00, 8'h24, 6'b000000, {10'h000, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0}};
        tbl[1]  = '{2'b01, 8'hC8, 6'b000000, {10'h320, 8'h00, 1'b0, 1'b0, 2'd0, 1'b1}};
        tbl[2]  = '{2'b00, 8'h25, 6'b000000, {10'h320, 8'h00, 1'b0, 1'b0, 2'd0, 1'b1}};
        tbl[3]  = '{2'b01, 8'h02, 6'b000000, {10'h322, 8'h00, 1'b0, 1'b0, 2'd0, 1'b1}};
        tbl[4]  = '{2'b00, 8'h26, 6'b000000, {10'h322, 8'h00, 1'b0, 1'b0, 2'd0, 1'b1}};
        tbl[5]  = '{2'b01, 8'h5A, 6'b000000, {10'h322, 8'h5A, 1'b0, 1'b0, 2'd0, 1'b1}};
        tbl[6]  = '{2'b00, 8'h27, 6'b000000, {10'h322, 8'h5A, 1'b0, 1'b0, 2'd0, 1'b1}};
        tbl[7]  = '{2'b01, 8'h01, 6'b001001, {10'h322, 8'h5A, 1'b0, 1'b0, 2'd0, 1'b1}};
        tbl[8]  = '{2'b01, 8'h01, 6'b001000, {10'h322, 8'h5A, 1'b0, 1'b0, 2'd0, 1'b1}};
        tbl[9]  = '{2'b01, 8'h00, 6'b001100, {10'h322, 8'h5A, 1'b0, 1'b0, 2'd0, 1'b1}};
        tbl[10] = '{2'b01, 8'h3F, 6'b110011, {10'h322, 8'h5A, 1'b1, 1'b1, 2'd0, 1'b1}};
        tbl[11] = '{2'b01, 8'hC3, 6'b000000, {10'h322, 8'h5A, 1'b0, 1'b0, 2'd3, 1'b1}};
        tbl[12] = '{2'b01, 8'h12, 6'b010100, {10'h322, 8'h5A, 1'b0, 1'b0, 2'd0, 1'b1}};
        tbl[13] = '{2'b01, 8'h31, 6'b111001, {10'h322, 8'h5A, 1'b0, 1'b0, 2'd0, 1'b1}};
        tbl[14] = '{2'b10, 8'h24, 6'b000000, {10'h322, 8'h5A, 1'b0, 1'b0, 2'd0, 1'b1}};
        tbl[15] = '{2'b11, 8'hFF, 6'b000000, {10'h322, 8'h5A, 1'b0, 1'b0, 2'd0, 1'b1}};
        tbl[16] = '{2'b01, 8'h00, 6'b000000, {10'h322, 8'h5A, 1'b0, 1'b0, 2'd0, 1'b1}};
        tbl[17] = '{2'b00, 8'h24, 6'b000000, {10'h322, 8'h5A, 1'b0, 1'b0, 2'd0, 1'b1}};
        tbl[18] = '{2'b11, 8'h00, 6'b000000, {10'h322, 8'h5A, 1'b0, 1'b0, 2'd0, 1'b1}};
        tbl[19] = '{2'b01, 8'h00, 6'b000000, {10'h002, 8'h5A, 1'b0, 1'b0, 2'd0, 1'b1}};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_levels", 64'(levels), 64'd0);
        check("reset_pulses", 64'(pulses), 64'd0);
        check("reset_dout", 64'(dout), 64'd0);

        for (int i = 0; i < 20; i++) begin
            bus_write(tbl[i].addr, tbl[i].din, tbl[i].pulse);
            check($sformatf("vec%0d_levels", i), 64'(levels), 64'(tbl[i].lvl));
        end

        wait_idle();
        busy_run(-1, 32, "busy_single");
        wait_idle();
        busy_run(10, 42, "busy_extend");

        flag_A = 1'b1; flag_B = 1'b0;
        @(posedge clk); @(negedge clk);
        check("dout_flagA", 64'(dout), 64'h01);
        flag_A = 1'b1; flag_B = 1'b1;
        @(posedge clk); @(negedge clk);
        check("dout_flags", 64'(dout), 64'h03);

        // ldA already stored 1: no load_A, only clr_run_B
        bus_write(2'b00, 8'h27, 6'b000000);
        bus_write(2'b01, 8'h01, 6'b001000);
        bus_write(2'b11, 8'h00, 6'b000000);
        check("pre_reset_busy", 64'(busy), 64'd1);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("async_rst_levels", 64'(levels), 64'd0);
        check("async_rst_dout", 64'(dout), 64'd0);
        check("async_rst_pulses", 64'(pulses), 64'd0);
        flag_A = 1'b0; flag_B = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        bus_write(2'b00, 8'h27, 6'b000000);
        bus_write(2'b01, 8'h01, 6'b001001);
        check("post_rst_levels", 64'(levels), {41'd0, 10'h000, 8'h00, 1'b0, 1'b0, 2'd0, 1'b1});

        repeat (3) @(negedge clk);
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
